strip_frame_loader: RTL
=======================

// Module: strip_frame_loader
// PURPOSE
//  Upstream stage of the multi-LED encoder. Accepts single-pixel writes over a valid/ready port into a
//  back (shadow) buffer and drives the LENGTH*24-bit strip bus from a front buffer. On a commit request,
//  the back buffer is copied to the front buffer inside the encoder's inter-frame gap, so a frame is never torn.
// PARAMETERS
//  LENGTH   10                   number of LEDs on the strip; must match the encoder's LENGTH
//  IDX_W    $clog2(LENGTH)+1     width of px_index; holds LENGTH so out-of-range indices can be expressed
// PORTS
//  clk            in   1          system clock, same clk that feeds the encoder
//  rst            in   1          synchronous reset, active-high
//  px_valid       in   1          pixel write request
//  px_ready       out  1          block accepts a pixel this cycle
//  px_index       in   IDX_W      LED index, 0 = LED nearest DO
//  px_rgb         in   24         pixel word {R,G,B}; stored unmodified, colour reordering is done downstream
//  commit         in   1          single-cycle pulse: publish the back buffer
//  commit_pending out  1          commit accepted, swap not yet done
//  sending_data   in   1          encoder busy flag, high while pixels are being shifted out
//  strip          out  LENGTH*24  front buffer; LED i is at strip[i*24 +: 24]
//  frame_count    out  8          number of completed swaps, wraps around
//  err_index      out  1          sticky: a write with px_index >= LENGTH was seen
// BEHAVIOUR
//  Reset (synchronous, while rst=1):
//   - front = back = 0, strip = 0, frame_count = 0, err_index = 0, commit_pending = 0
//   - px_ready = 0 while rst is asserted; FSM goes to IDLE; sync flops cleared
//  Reset mid-operation:
//   - any pending commit is discarded; a px_valid held high across reset is not accepted until IDLE
//  Pixel handshake:
//   - a transfer occurs on the clk edge where px_valid && px_ready
//   - back[px_index] <= px_rgb on that edge
//   - px_valid may stay high across cycles; one write per accepted cycle
//   - px_index >= LENGTH: handshake still completes, the write is dropped, err_index <= 1 (held until rst)
//  sending_data sampling:
//   - 2-flop synchroniser s1,s2, then s3 <= s2
//   - gap_edge = s3 & ~s2 (falling edge); it is a 1-cycle pulse 3 clk after sending_data falls
//  FSM states IDLE, PENDING, SWAP:
//   - IDLE: px_ready=1. If commit=1, go to PENDING. A pixel accepted in the same cycle as commit is
//     written and is included in the commit.
//   - PENDING: px_ready=0, commit_pending=1; further commit pulses are merged (ignored).
//     Go to SWAP on gap_edge. Also go to SWAP if s2==0 and no_frame_yet=1 (encoder never started since
//     reset), so the first frame cannot deadlock.
//   - SWAP (exactly 1 cycle): front <= back (full copy, back retained so edits are incremental);
//     frame_count <= frame_count+1 (mod 256); clear no_frame_yet; commit_pending=0 on exit; back to IDLE.
//  Output latency:
//   - strip updates on the edge that leaves SWAP
//   - commit-to-strip latency is at least 2 clk (no-frame case); otherwise bounded by the next encoder gap + 4 clk
//  no_frame_yet: set by reset, cleared on the first s2 rising.
//  strip, frame_count and err_index are registered outputs only; no combinational path from inputs.
//  The encoder's gap lasts 10 pixel slots (about 292 us), which is far longer than the 4-clk swap path,
//  so the swap always lands inside the gap.
// TESTING
//  1. rst=1 for 2 clk with px_valid=1 -> strip=0, px_ready=0, frame_count=0, err_index=0; px_ready=1 the cycle after rst drops.
//  2. Write idx0=FF0000, idx9=0000FF, then commit with sending_data=0 since reset -> strip[23:0]=FF0000,
//     strip[239:216]=0000FF, frame_count=1, 2 clk after commit.
//  3. sending_data=1, write idx3=00FF00, commit -> strip unchanged and commit_pending=1 while sending_data=1,
//     px_ready=0; drop sending_data -> strip[95:72]=00FF00 exactly 4 clk later.
//  4. px_index=LENGTH (10) with px_rgb=123456 -> handshake completes, strip and back unchanged, err_index=1 held until rst.
//  5. commit pulsed 3 times while PENDING, then one gap_edge -> exactly one swap, frame_count +1; same-cycle write+commit in IDLE is included.
//  6. Preload frame_count=255 via 255 commits, then commit once more -> 0; rst during PENDING -> commit_pending=0, strip=0, no swap at the next gap.

Source files
------------

// File: rtl/strip_frame_loader.sv
// rtl/strip_frame_loader.sv - pixel write port, shadow buffer and tear-free front-buffer swap for the LED strip encoder
//
// Ports:
//   clk            system clock, shared with the encoder
//   rst            synchronous reset, active-high
//   px_valid       pixel write request
//   px_ready       pixel write accepted this cycle (registered)
//   px_index       LED index, 0 = LED nearest DO; values >= LENGTH are flagged and dropped
//   px_rgb         pixel word {R,G,B}, stored unmodified
//   commit         single-cycle pulse: publish the back buffer
//   commit_pending commit accepted, swap not yet done
//   sending_data   encoder busy flag (asynchronous to the swap decision, hence synchronised)
//   strip          front buffer, LED i at strip[i*24 +: 24]
//   frame_count    completed swaps, wraps at 256
//   err_index      sticky out-of-range write flag
module strip_frame_loader #(
  parameter int LENGTH = 10,
  parameter int IDX_W  = $clog2(LENGTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   px_valid,
  output logic                   px_ready,
  input  logic [IDX_W-1:0]       px_index,
  input  logic [23:0]            px_rgb,
  input  logic                   commit,
  output logic                   commit_pending,
  input  logic                   sending_data,
  output logic [LENGTH*24-1:0]   strip,
  output logic [7:0]             frame_count,
  output logic                   err_index
);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    SWAP
  } state_t;

  state_t                 state;
  logic                   s1;
  logic                   s2;
  logic                   s3;
  logic                   no_frame_yet;
  logic [LENGTH*24-1:0]   back;
  logic                   gap_edge;
  logic                   px_accept;
  logic                   in_range;

  // Falling edge of the synchronised busy flag marks the start of the inter-frame gap.
  assign gap_edge  = s3 & ~s2;
  assign px_accept = px_valid & px_ready;
  assign in_range  = px_index < IDX_W'(LENGTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      px_ready       <= 1'b0;
      commit_pending <= 1'b0;
      s1             <= 1'b0;
      s2             <= 1'b0;
      s3             <= 1'b0;
      no_frame_yet   <= 1'b1;
      back           <= '0;
      strip          <= '0;
      frame_count    <= '0;
      err_index      <= 1'b0;
    end else begin
      s1 <= sending_data;
      s2 <= s1;
      s3 <= s2;

      // Once the encoder has been seen running, gaps are trusted to arrive.
      if (s2 && !s3)
        no_frame_yet <= 1'b0;

      // Out-of-range writes still complete the handshake so the producer never stalls.
      if (px_accept) begin
        if (in_range) begin
          for (int i = 0; i < LENGTH; i++) begin
            if (px_index == IDX_W'(i))
              back[i*24 +: 24] <= px_rgb;
          end
        end else begin
          err_index <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          px_ready <= 1'b1;
          if (commit) begin
            state          <= PENDING;
            px_ready       <= 1'b0;
            commit_pending <= 1'b1;
          end
        end
        PENDING: begin
          // Extra commits here are merged; the no-frame escape avoids waiting
          // forever for a gap from an encoder that has never started.
          if (gap_edge || (!s2 && no_frame_yet))
            state <= SWAP;
        end
        SWAP: begin
          // Back buffer is kept so the next frame can be edited incrementally.
          strip          <= back;
          frame_count    <= frame_count + 8'd1;
          no_frame_yet   <= 1'b0;
          commit_pending <= 1'b0;
          px_ready       <= 1'b1;
          state          <= IDLE;
        end
        default: begin
          state    <= IDLE;
          px_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
